// File: rtl/timer_pkg.sv
// Shared types for the countdown timer: the controller state encoding.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } timer_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with one-shot / auto-reload modes, pause and abort.
// Pulses 'expired' on terminal count and tallies expiries in a saturating counter.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    input  logic             pause,
    input  logic             stop,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             expired,
    output logic [CNT_W-1:0] expire_count
);

    timer_state_e     state, state_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic             auto_reg, auto_next;
    logic             expired_next;

    assign load_ready = (state == IDLE);
    assign busy       = (state != IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_next   = state;
        q_next       = q;
        reload_next  = reload_reg;
        auto_next    = auto_reg;
        expired_next = 1'b0;

        unique case (state)
            IDLE: begin
                if (load_valid) begin
                    if (load_value == '0) begin
                        expired_next = 1'b1;
                        q_next       = '0;
                    end else begin
                        q_next      = load_value;
                        reload_next = load_value;
                        auto_next   = auto_reload;
                        state_next  = RUN;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    q_next     = '0;
                    state_next = IDLE;
                end else if (pause) begin
                    state_next = PAUSED;
                end else if (q == WIDTH'(1)) begin
                    expired_next = 1'b1;
                    if (auto_reg) begin
                        q_next = reload_reg;
                    end else begin
                        q_next     = '0;
                        state_next = IDLE;
                    end
                end else if (q != '0) begin
                    q_next = q - WIDTH'(1);
                end
            end
            PAUSED: begin
                // Resuming only changes state; the decrement restarts on the following edge.
                if (stop) begin
                    q_next     = '0;
                    state_next = IDLE;
                end else if (!pause) begin
                    state_next = RUN;
                end
            end
            default: begin
                q_next     = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state      <= IDLE;
            q          <= '0;
            reload_reg <= '0;
            auto_reg   <= 1'b0;
            expired    <= 1'b0;
        end else begin
            state      <= state_next;
            q          <= q_next;
            reload_reg <= reload_next;
            auto_reg   <= auto_next;
            expired    <= expired_next;
        end
    end

    // Counting on expired_next keeps expire_count in step with the pulse itself.
    sat_counter #(.W(CNT_W)) u_expire_count (
        .clk (clk),
        .rst (rst),
        .inc (expired_next),
        .q   (expire_count)
    );

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed vector table, randomized run
// against a behavioural model, and a narrow-counter saturation sequence.
module tb_countdown_timer;

    logic        clk = 1'b0;
    logic        rst, load_valid, auto_reload, pause, stop;
    logic [31:0] load_value;
    logic        load_ready, busy, expired;
    logic [31:0] q;
    logic [7:0]  expire_count;

    // Narrow instance used for the saturation corner case.
    logic       sm_rst, sm_load_valid, sm_auto;
    logic [7:0] sm_load_value;
    logic       sm_load_ready, sm_busy, sm_expired;
    logic [7:0] sm_q;
    logic [1:0] sm_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(32), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_value   (load_value),
        .auto_reload  (auto_reload),
        .pause        (pause),
        .stop         (stop),
        .q            (q),
        .busy         (busy),
        .expired      (expired),
        .expire_count (expire_count)
    );

    countdown_timer #(.WIDTH(8), .CNT_W(2)) dut_small (
        .clk          (clk),
        .rst          (sm_rst),
        .load_valid   (sm_load_valid),
        .load_ready   (sm_load_ready),
        .load_value   (sm_load_value),
        .auto_reload  (sm_auto),
        .pause        (1'b0),
        .stop         (1'b0),
        .q            (sm_q),
        .busy         (sm_busy),
        .expired      (sm_expired),
        .expire_count (sm_count)
    );

    typedef struct {
        logic        rst;
        logic        lv;
        logic [31:0] val;
        logic        auto_r;
        logic        pause;
        logic        stop;
        logic [31:0] exp_q;
        logic        exp_busy;
        logic        exp_expired;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic lv, input logic [31:0] val, input logic a,
                       input logic p, input logic s, input logic [31:0] eq, input logic eb,
                       input logic ee, input logic [7:0] ec);
        vec_t v;
        v.rst = r; v.lv = lv; v.val = val; v.auto_r = a; v.pause = p; v.stop = s;
        v.exp_q = eq; v.exp_busy = eb; v.exp_expired = ee; v.exp_cnt = ec;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic lv, input logic [31:0] val,
                         input logic a, input logic p, input logic s);
        rst = r; load_valid = lv; load_value = val; auto_reload = a; pause = p; stop = s;
    endtask

    // Behavioural reference: remaining count plus running/frozen flags.
    bit          m_active, m_frozen, m_auto, m_exp;
    longint      m_rem, m_reload;
    int          m_cnt;

    task automatic model_step(input logic r, input logic lv, input logic [31:0] val,
                              input logic a, input logic p, input logic s);
        m_exp = 0;
        if (r) begin
            m_active = 0; m_frozen = 0; m_auto = 0; m_rem = 0; m_reload = 0; m_cnt = 0;
        end else if (!m_active) begin
            if (lv) begin
                if (val == 0) begin
                    m_exp = 1;
                    m_rem = 0;
                end else begin
                    m_rem = longint'(val); m_reload = longint'(val); m_auto = a;
                    m_active = 1; m_frozen = 0;
                end
            end
        end else if (s) begin
            m_rem = 0; m_active = 0; m_frozen = 0;
        end else if (m_frozen) begin
            if (!p) m_frozen = 0;
        end else if (p) begin
            m_frozen = 1;
        end else if (m_rem == 1) begin
            m_exp = 1;
            if (m_auto) m_rem = m_reload;
            else begin
                m_rem = 0; m_active = 0;
            end
        end else begin
            m_rem = m_rem - 1;
        end
        if (m_exp && m_cnt < 255) m_cnt++;
    endtask

    initial begin
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        sm_rst = 1'b1; sm_load_valid = 1'b0; sm_load_value = 8'd0; sm_auto = 1'b0;

        //   rst lv val           au pa st   q             busy exp cnt
        add(1, 0, 32'd0,         0, 0, 0,  32'd0,         0, 0, 8'd0);
        add(1, 0, 32'd0,         0, 0, 0,  32'd0,         0, 0, 8'd0);
        // one-shot load 5
        add(0, 1, 32'd5,         0, 0, 0,  32'd5,         1, 0, 8'd0);
        add(0, 0, 32'd0,         0, 0, 0,  32'd4,         1, 0, 8'd0);
        add(0, 0, 32'd0,         0, 0, 0,  32'd3,         1, 0, 8'd0);
        add(0, 0, 32'd0,         0, 0, 0,  32'd2,         1, 0, 8'd0);
        add(0, 0, 32'd0,         0, 0, 0,  32'd1,         1, 0, 8'd0);
        add(0, 0, 32'd0,         0, 0, 0,  32'd0,         0, 1, 8'd1);
        add(0, 0, 32'd0,         0, 0, 0,  32'd0,         0, 0, 8'd1);
        // auto-reload load 3: pulses 3, 6, 9 edges after accept
        add(0, 1, 32'd3,         1, 0, 0,  32'd3,         1, 0, 8'd1);
        for (int k = 0; k < 3; k++) begin
            add(0, 0, 32'd0,     0, 0, 0,  32'd2,         1, 0, 8'(1 + k));
            add(0, 0, 32'd0,     0, 0, 0,  32'd1,         1, 0, 8'(1 + k));
            add(0, 0, 32'd0,     0, 0, 0,  32'd3,         1, 1, 8'(2 + k));
        end
        add(0, 0, 32'd0,         0, 0, 1,  32'd0,         0, 0, 8'd4);
        // load 4, pause three cycles after one decrement
        add(0, 1, 32'd4,         0, 0, 0,  32'd4,         1, 0, 8'd4);
        add(0, 0, 32'd0,         0, 0, 0,  32'd3,         1, 0, 8'd4);
        add(0, 0, 32'd0,         0, 1, 0,  32'd3,         1, 0, 8'd4);
        add(0, 0, 32'd0,         0, 1, 0,  32'd3,         1, 0, 8'd4);
        add(0, 0, 32'd0,         0, 1, 0,  32'd3,         1, 0, 8'd4);
        add(0, 0, 32'd0,         0, 0, 0,  32'd3,         1, 0, 8'd4);
        add(0, 0, 32'd0,         0, 0, 0,  32'd2,         1, 0, 8'd4);
        add(0, 0, 32'd0,         0, 0, 0,  32'd1,         1, 0, 8'd4);
        add(0, 0, 32'd0,         0, 0, 0,  32'd0,         0, 1, 8'd5);
        // load 6, stop at q=2
        add(0, 1, 32'd6,         0, 0, 0,  32'd6,         1, 0, 8'd5);
        add(0, 0, 32'd0,         0, 0, 0,  32'd5,         1, 0, 8'd5);
        add(0, 0, 32'd0,         0, 0, 0,  32'd4,         1, 0, 8'd5);
        add(0, 0, 32'd0,         0, 0, 0,  32'd3,         1, 0, 8'd5);
        add(0, 0, 32'd0,         0, 0, 0,  32'd2,         1, 0, 8'd5);
        add(0, 0, 32'd0,         0, 0, 1,  32'd0,         0, 0, 8'd5);
        add(0, 0, 32'd0,         0, 0, 0,  32'd0,         0, 0, 8'd5);
        // load 0: immediate pulse, never busy
        add(0, 1, 32'd0,         0, 0, 0,  32'd0,         0, 1, 8'd6);
        add(0, 0, 32'd0,         0, 0, 0,  32'd0,         0, 0, 8'd6);
        // load with stop in IDLE is taken; stop beats terminal count
        add(0, 1, 32'd2,         0, 0, 1,  32'd2,         1, 0, 8'd6);
        add(0, 0, 32'd0,         0, 0, 0,  32'd1,         1, 0, 8'd6);
        add(0, 0, 32'd0,         0, 0, 1,  32'd0,         0, 0, 8'd6);
        // load while busy is ignored
        add(0, 1, 32'd3,         0, 0, 0,  32'd3,         1, 0, 8'd6);
        add(0, 1, 32'd9,         1, 0, 0,  32'd2,         1, 0, 8'd6);
        add(0, 0, 32'd0,         0, 0, 0,  32'd1,         1, 0, 8'd6);
        add(0, 0, 32'd0,         0, 0, 0,  32'd0,         0, 1, 8'd7);
        // max load, then reset mid-RUN wins over load
        add(0, 1, 32'hFFFF_FFFF, 0, 0, 0,  32'hFFFF_FFFF, 1, 0, 8'd7);
        add(0, 0, 32'd0,         0, 0, 0,  32'hFFFF_FFFE, 1, 0, 8'd7);
        add(1, 1, 32'd7,         0, 0, 0,  32'd0,         0, 0, 8'd0);
        // pause/stop ignored in IDLE; stop while paused
        add(0, 0, 32'd0,         0, 1, 1,  32'd0,         0, 0, 8'd0);
        add(0, 1, 32'd2,         0, 0, 0,  32'd2,         1, 0, 8'd0);
        add(0, 0, 32'd0,         0, 1, 0,  32'd2,         1, 0, 8'd0);
        add(0, 0, 32'd0,         0, 1, 1,  32'd0,         0, 0, 8'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].lv, vecs[i].val, vecs[i].auto_r, vecs[i].pause, vecs[i].stop);
            tick();
            check($sformatf("vec%0d.q", i),          64'(q),            64'(vecs[i].exp_q));
            check($sformatf("vec%0d.busy", i),       64'(busy),         64'(vecs[i].exp_busy));
            check($sformatf("vec%0d.load_ready", i), 64'(load_ready),   64'(!vecs[i].exp_busy));
            check($sformatf("vec%0d.expired", i),    64'(expired),      64'(vecs[i].exp_expired));
            check($sformatf("vec%0d.count", i),      64'(expire_count), 64'(vecs[i].exp_cnt));
        end

        // Randomized run against the reference model.
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        model_step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 3000; c++) begin
            logic        r, lv, a, p, s;
            logic [31:0] val;
            r   = ($urandom_range(0, 199) == 0);
            lv  = ($urandom_range(0, 9) < 3);
            val = ($urandom_range(0, 39) == 0) ? $urandom : 32'($urandom_range(0, 6));
            a   = $urandom_range(0, 1) == 1;
            p   = ($urandom_range(0, 9) < 2);
            s   = ($urandom_range(0, 29) == 0);
            drive(r, lv, val, a, p, s);
            model_step(r, lv, val, a, p, s);
            tick();
            check($sformatf("rand%0d.q", c),       64'(q),            64'(m_rem));
            check($sformatf("rand%0d.busy", c),    64'({busy, load_ready}), 64'({m_active, !m_active}));
            check($sformatf("rand%0d.expired", c), 64'(expired),      64'(m_exp));
            check($sformatf("rand%0d.count", c),   64'(expire_count), 64'(m_cnt));
        end
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Narrow counter: auto-reload of 1 pulses every cycle and saturates at 3.
        sm_rst = 1'b1;
        tick();
        sm_rst = 1'b0; sm_load_valid = 1'b1; sm_load_value = 8'd1; sm_auto = 1'b1;
        tick();
        check("sat.accept_q", 64'(sm_q), 64'd1);
        check("sat.accept_busy", 64'(sm_busy), 64'd1);
        sm_load_valid = 1'b0; sm_load_value = 8'd0; sm_auto = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("sat.count%0d", k), 64'(sm_count), 64'((k < 3) ? k : 3));
            check($sformatf("sat.pulse%0d", k), 64'({sm_expired, sm_q}), 64'({1'b1, 8'd1}));
        end
        sm_rst = 1'b1;
        tick();
        check("sat.reset", 64'({sm_q, sm_busy, sm_load_ready, sm_expired, sm_count}),
              64'({8'd0, 1'b0, 1'b1, 1'b0, 2'd0}));
        sm_rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
